if_stage: RTL and testbench

- Instruction-fetch stage; sits directly upstream of the decode stage.
- Generates the sequential PC and issues reads to a fixed 1-cycle-latency instruction memory.
- Buffers returned instructions in a small FIFO and presents {instr, pc} to decode with a valid/allowin handshake.
- Accepts taken-branch/jump redirects from decode and flushes wrong-path fetches.

---
 rtl/if_stage.sv | 115 +++++++++++
 tb/tb_if_stage.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// Purpose : instruction fetch; sequential PC, 1-cycle imem reads, small fetch buffer, redirect flush.
// Latency : issue in cycle N, instruction visible to decode in cycle N+2; one per cycle when streaming.
// Backpr. : credit check (buffered + in-flight - popped < BUF_DEPTH) stops issue before the buffer can overflow.
//
// Ports:
//   clk, resetn         clock; synchronous active-low reset
//   ds_allowin          decode accepts fs_data this cycle
//   branch_data         {br_taken, br_target} from decode, combinational one-cycle pulse
//   inst_en, inst_addr  instruction memory read request / word-aligned address
//   inst_rdata          read data, valid one cycle after inst_en
//   fs_to_ds_valid      fs_data carries a valid instruction
//   fs_data             {instr, pc} of the buffer head, zero when empty
module if_stage #(
    parameter logic [31:0] RESET_PC  = 32'h8000_0000,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        ds_allowin,
    input  logic [32:0] branch_data,
    output logic        inst_en,
    output logic [31:0] inst_addr,
    input  logic [31:0] inst_rdata,
    output logic        fs_to_ds_valid,
    output logic [63:0] fs_data
);

    localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    // One extra bit beyond count's 0..BUF_DEPTH range so the credit sum cannot wrap.
    localparam int CW = PW + 2;

    logic [31:0] fetch_pc;
    logic [31:0] req_pc;
    logic        inflight;
    logic        drop;
    logic [63:0] buf_mem [BUF_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;

    logic          br_taken;
    logic [31:0]   br_target;
    logic          buf_nonempty;
    logic          pop;
    logic          push;
    logic [CW-1:0] occupancy;
    logic          unused_br_low;

    assign br_taken      = branch_data[32];
    // Targets are forced onto a word boundary; the low bits are ignored.
    assign br_target     = {branch_data[31:2], 2'b00};
    assign unused_br_low = ^branch_data[1:0];

    assign buf_nonempty   = (count != '0);
    // A redirect kills the head in the same cycle, so decode never sees it.
    assign fs_to_ds_valid = resetn & buf_nonempty & ~br_taken;
    assign fs_data        = (resetn && buf_nonempty) ? buf_mem[rd_ptr] : 64'h0;
    assign pop            = fs_to_ds_valid & ds_allowin;

    // pop implies count != 0, so the subtraction never underflows.
    assign occupancy = count + CW'(inflight) - CW'(pop);
    // A redirect always issues its target fetch: the buffer is flushed at the
    // end of this cycle, so the credit for that response is guaranteed.
    assign inst_en   = resetn & (br_taken | (occupancy < CW'(BUF_DEPTH)));
    assign inst_addr = br_taken ? br_target : fetch_pc;

    // The response landing in a redirect cycle belongs to the old path.
    assign push = inflight & ~drop & ~br_taken;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            fetch_pc <= RESET_PC;
            req_pc   <= 32'h0;
            inflight <= 1'b0;
            drop     <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
        end else begin
            inflight <= inst_en;
            // A redirect that issued nothing would leave a wrong-path response
            // outstanding; mark it so it is not pushed next cycle.
            drop     <= br_taken & ~inst_en;
            if (inst_en) begin
                req_pc   <= inst_addr;
                fetch_pc <= inst_addr + 32'd4;
            end
            if (br_taken) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + PW'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PW'(1);
                end
                count <= count + CW'(push) - CW'(pop);
            end
        end
    end

    // Buffer storage needs no reset: entries are only read when count says valid.
    always_ff @(posedge clk) begin
        if (resetn && push) begin
            buf_mem[wr_ptr] <= {inst_rdata, req_pc};
        end
    end

    // The credit rule must make this unreachable.
    a_no_overflow: assert property (@(posedge clk) disable iff (!resetn)
        !(push && !pop && (count == CW'(BUF_DEPTH))));

endmodule

// File: tb/tb_if_stage.sv
// Purpose : self-checking bench for if_stage against a queue-level fetch model.
// Latency : model predicts every output each cycle; directed phases then random traffic.
// Backpr. : ds_allowin stalls and redirects are exercised; buffer overflow is flagged by the model.
module tb_if_stage;

    localparam logic [31:0] RPC = 32'h8000_0000;
    localparam int          D   = 2;
    localparam logic [31:0] KEY = 32'hA5A5_A5A5;

    logic        clk = 1'b0;
    logic        resetn;
    logic        ds_allowin;
    logic [32:0] branch_data;
    logic        inst_en;
    logic [31:0] inst_addr;
    logic [31:0] inst_rdata;
    logic        fs_to_ds_valid;
    logic [63:0] fs_data;

    if_stage #(.RESET_PC(RPC), .BUF_DEPTH(D)) dut (
        .clk            (clk),
        .resetn         (resetn),
        .ds_allowin     (ds_allowin),
        .branch_data    (branch_data),
        .inst_en        (inst_en),
        .inst_addr      (inst_addr),
        .inst_rdata     (inst_rdata),
        .fs_to_ds_valid (fs_to_ds_valid),
        .fs_data        (fs_data)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: a plain queue of {instr, pc} plus the one outstanding request.
    logic [31:0] m_pc;
    bit          m_infl;
    logic [31:0] m_infl_pc;
    logic [63:0] m_q [$];
    bit          mem_vld;
    logic [31:0] mem_addr;
    logic [31:0] deliv [$];

    // Last sampled DUT outputs, for literal checks after a step.
    logic        s_en;
    logic [31:0] s_addr;
    logic        s_vld;
    logic [63:0] s_dat;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input bit rst_n, input bit allow, input bit br, input logic [31:0] tgt);
        bit          e_vld;
        logic [63:0] e_dat;
        bit          e_en;
        logic [31:0] e_addr;
        bit          pop;
        int          occ;
        @(posedge clk);
        #1;
        resetn      = rst_n;
        ds_allowin  = allow;
        branch_data = {br, tgt};
        inst_rdata  = mem_vld ? (mem_addr ^ KEY) : $urandom;
        #1;
        e_vld  = rst_n && (m_q.size() != 0) && !br;
        e_dat  = (rst_n && m_q.size() != 0) ? m_q[0] : 64'h0;
        pop    = e_vld && allow;
        occ    = m_q.size() + int'(m_infl) - int'(pop);
        e_en   = rst_n && (br || occ < D);
        e_addr = br ? {tgt[31:2], 2'b00} : m_pc;

        s_en = inst_en; s_addr = inst_addr; s_vld = fs_to_ds_valid; s_dat = fs_data;
        chk("fs_to_ds_valid", {63'b0, fs_to_ds_valid}, {63'b0, e_vld});
        chk("fs_data", fs_data, e_dat);
        chk("inst_en", {63'b0, inst_en}, {63'b0, e_en});
        if (e_en) chk("inst_addr", {32'b0, inst_addr}, {32'b0, e_addr});
        if (fs_to_ds_valid && allow) deliv.push_back(fs_data[31:0]);

        mem_vld  = e_en;
        mem_addr = e_addr;
        if (!rst_n) begin
            m_pc   = RPC;
            m_infl = 0;
            m_q.delete();
        end else begin
            if (pop) void'(m_q.pop_front());
            if (br) m_q.delete();
            else if (m_infl) m_q.push_back({m_infl_pc ^ KEY, m_infl_pc});
            if (m_q.size() > D) begin
                n_cmp++; n_bad++;
                $display("FAIL model_overflow: size %0d limit %0d", m_q.size(), D);
            end
            m_infl = e_en;
            if (e_en) begin
                m_infl_pc = e_addr;
                m_pc      = e_addr + 32'd4;
            end
        end
    endtask

    initial begin
        resetn = 1'b0; ds_allowin = 1'b0; branch_data = '0; inst_rdata = '0;
        m_pc = RPC; m_infl = 0; m_infl_pc = '0; mem_vld = 0; mem_addr = '0;

        // Held in reset
        step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        chk("rst_inst_en", {63'b0, s_en}, 64'd0);
        chk("rst_valid", {63'b0, s_vld}, 64'd0);
        chk("rst_data", s_dat, 64'd0);

        // Streaming from reset
        deliv.delete();
        step(1, 1, 0, 0);
        chk("first_en", {63'b0, s_en}, 64'd1);
        chk("first_addr", {32'b0, s_addr}, 64'h8000_0000);
        step(1, 1, 0, 0);
        chk("second_addr", {32'b0, s_addr}, 64'h8000_0004);
        step(1, 1, 0, 0);
        chk("first_valid", {63'b0, s_vld}, 64'd1);
        chk("first_data", s_dat, 64'h25A5A5A5_80000000);
        for (int i = 0; i < 4; i++) step(1, 1, 0, 0);
        // Stall then release
        for (int i = 0; i < 4; i++) step(1, 0, 0, 0);
        chk("stall_en", {63'b0, s_en}, 64'd0);
        for (int i = 0; i < 6; i++) step(1, 1, 0, 0);
        chk("stream_first_pc", {32'b0, deliv[0]}, 64'h8000_0000);
        for (int i = 1; i < deliv.size(); i++)
            chk("stream_seq", {32'b0, deliv[i]}, {32'b0, deliv[i-1] + 32'd4});

        // Redirect while 0x80000008 is at the head and 0x8000000C in flight
        step(0, 1, 0, 0);
        for (int i = 0; i < 4; i++) step(1, 1, 0, 0);
        deliv.delete();
        step(1, 1, 1, 32'h8000_0100);
        chk("br_head_pc", {32'b0, s_dat[31:0]}, 64'h8000_0008);
        chk("br_valid", {63'b0, s_vld}, 64'd0);
        chk("br_addr", {32'b0, s_addr}, 64'h8000_0100);
        for (int i = 0; i < 4; i++) step(1, 1, 0, 0);
        chk("br_deliv0", {32'b0, deliv[0]}, 64'h8000_0100);
        chk("br_deliv1", {32'b0, deliv[1]}, 64'h8000_0104);

        // Redirect with a full buffer and decode stalled, misaligned target
        for (int i = 0; i < 5; i++) step(1, 0, 0, 0);
        deliv.delete();
        step(1, 0, 1, 32'h8000_0102);
        chk("full_br_addr", {32'b0, s_addr}, 64'h8000_0100);
        step(1, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(1, 1, 0, 0);
        chk("full_br_deliv0", {32'b0, deliv[0]}, 64'h8000_0100);

        // Address wrap
        deliv.delete();
        step(1, 1, 1, 32'hFFFF_FFFC);
        for (int i = 0; i < 5; i++) step(1, 1, 0, 0);
        chk("wrap_deliv0", {32'b0, deliv[0]}, 64'hFFFF_FFFC);
        chk("wrap_deliv1", {32'b0, deliv[1]}, 64'h0000_0000);

        // Reset mid-stream with the buffer full
        for (int i = 0; i < 4; i++) step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        step(1, 1, 0, 0);
        chk("mid_rst_valid", {63'b0, s_vld}, 64'd0);
        chk("mid_rst_data", s_dat, 64'd0);
        chk("mid_rst_en", {63'b0, s_en}, 64'd1);
        chk("mid_rst_addr", {32'b0, s_addr}, 64'h8000_0000);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 199) != 0,
                 $urandom_range(0, 3) != 0,
                 $urandom_range(0, 11) == 0,
                 $urandom);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
